// File: rtl/bb_slave_port.sv
// bb_slave_port: bit-serial bus slave. Receives a 16-bit address MSB first; the top
// nibble selects this device. Writes shift in 8 data bits and issue one local write strobe;
// reads issue one local read strobe, wait any latency for the data, then shift it out MSB first.
// Optional feature: define BB_SLAVE_SPLIT_EN to drive split while read data is pending;
// without it split is tied low.
module bb_slave_port #(
    parameter logic [3:0]  DEVICE_ID = 4'h0,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mode,
    input  logic              wr_bus,
    input  logic              master_valid,
    output logic              slave_ready,
    output logic              ack,
    output logic              rd_bus,
    output logic              slave_valid,
    input  logic              master_ready,
    output logic              split,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wr_data,
    output logic              s_wr_en,
    output logic              s_rd_en,
    input  logic [7:0]        s_rd_data,
    input  logic              s_rd_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StIgnore,
        StWdata,
        StWrCommit,
        StRdReq,
        StRdWait,
        StRdData
    } state_e;

    state_e      state_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic [3:0]  count_q;
    logic        ack_q;
    logic        beat;
    logic        addr_valid;

    // The address MSB is only needed for the device-select compare, which happens on the fly.
    logic unused_addr_msb;
    assign unused_addr_msb = addr_q[15];

    assign beat = master_valid & slave_ready;

    // Transfer sequencing: address capture, device select, write/read data movement.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (beat) begin
                        addr_q  <= {15'd0, wr_bus};
                        count_q <= 4'd1;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (!master_valid) begin
                        // Master gave up mid-address: drop the transfer silently.
                        state_q <= StIdle;
                        ack_q   <= 1'b0;
                        count_q <= '0;
                    end else begin
                        addr_q  <= {addr_q[14:0], wr_bus};
                        count_q <= count_q + 4'd1;
                        if (count_q == 4'd3) begin
                            if ({addr_q[2:0], wr_bus} == DEVICE_ID) begin
                                ack_q <= 1'b1;
                            end else begin
                                state_q <= StIgnore;
                                count_q <= '0;
                            end
                        end else if (count_q == 4'd15) begin
                            ack_q   <= 1'b0;
                            count_q <= '0;
                            state_q <= mode ? StWdata : StRdReq;
                        end
                    end
                end
                StIgnore: begin
                    if (!master_valid) begin
                        state_q <= StIdle;
                    end
                end
                StWdata: begin
                    if (!master_valid) begin
                        state_q <= StIdle;
                        count_q <= '0;
                    end else begin
                        data_q  <= {data_q[6:0], wr_bus};
                        count_q <= count_q + 4'd1;
                        if (count_q == 4'd7) begin
                            count_q <= '0;
                            state_q <= StWrCommit;
                        end
                    end
                end
                StWrCommit: begin
                    state_q <= StIdle;
                end
                StRdReq: begin
                    // Zero-latency memories may answer in the same cycle as the request.
                    if (s_rd_valid) begin
                        data_q  <= s_rd_data;
                        state_q <= StRdData;
                    end else begin
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (s_rd_valid) begin
                        data_q  <= s_rd_data;
                        state_q <= StRdData;
                    end
                end
                StRdData: begin
                    if (master_ready) begin
                        data_q  <= {data_q[6:0], 1'b0};
                        count_q <= count_q + 4'd1;
                        if (count_q == 4'd7) begin
                            count_q <= '0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output decode from registered state only, so every output is glitch-free.
    always_comb begin
        slave_ready = (state_q == StIdle) || (state_q == StAddr) || (state_q == StWdata);
        addr_valid  = (state_q == StWdata) || (state_q == StWrCommit) ||
                      (state_q == StRdReq) || (state_q == StRdWait) || (state_q == StRdData);
        ack         = ack_q;
        s_addr      = addr_valid ? addr_q[ADDR_W-1:0] : '0;
        s_wr_data   = data_q;
        s_wr_en     = (state_q == StWrCommit);
        s_rd_en     = (state_q == StRdReq);
        slave_valid = (state_q == StRdData);
        rd_bus      = (state_q == StRdData) & data_q[7];
`ifdef BB_SLAVE_SPLIT_EN
        split       = (state_q == StRdReq) || (state_q == StRdWait);
`else
        split       = 1'b0;
`endif
    end

endmodule
